alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SEC, 60, ring duration in tick_1hz pulses before auto-off.
REQ-002 Parameter SNOOZE_MIN, 5, snooze delay in minutes.
REQ-003 Parameter MAX_SNOOZE, 3, snoozes allowed per alarm event.
REQ-004 clk  in  1  system clock; single clock domain, all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 tick_1hz  in  1  one-cycle pulse per second from timebase.
REQ-007 cur_hr  in  5  current hour, 0-23; cur_min  in  6  current minute, 0-59.
REQ-008 alm_hr  in  5  alarm hour; alm_min  in  6  alarm minute.
REQ-009 alarm_en  in  1  level; alarm armed.
REQ-010 setting_active  in  1  level; high while the time or alarm is being set.
REQ-011 dismiss  in  1  one-cycle pulse; stop alarm.
REQ-012 snooze  in  1  one-cycle pulse; request snooze.
REQ-013 buzz  out  1  buzzer drive.
REQ-014 ringing  out  1  high in RING; snoozed  out  1  high in SNOOZE.
REQ-015 alm_state  out  2  state code: IDLE=0, RING=1, SNOOZE=2, DONE=3.
REQ-016 snooze_cnt  out  3  snoozes taken in the current event.

Function
REQ-017 All outputs SHALL decode registered state, so each response appears the cycle after its cause is sampled.
REQ-018 match SHALL be defined as (cur_hr==alm_hr)&&(cur_min==alm_min); trigger = match && alarm_en && !setting_active.
REQ-019 IDLE: trigger SHALL move to RING, loading ring_cnt=RING_SEC.
REQ-020 RING: each tick_1hz SHALL decrement ring_cnt; a tick with ring_cnt==1 SHALL move to DONE (RING lasts exactly RING_SEC ticks).
REQ-021 RING: snooze with snooze_cnt<MAX_SNOOZE SHALL move to SNOOZE, increment snooze_cnt, and load snz_cnt=SNOOZE_MIN*60 (16-bit counter).
REQ-022 RING: snooze with snooze_cnt==MAX_SNOOZE SHALL be ignored (remain in RING, counters unchanged).
REQ-023 SNOOZE: each tick_1hz SHALL decrement snz_cnt; a tick with snz_cnt==1 SHALL move to RING, reloading ring_cnt=RING_SEC.
REQ-024 RING or SNOOZE: dismiss, or alarm_en==0, SHALL move to DONE.
REQ-025 Entering DONE SHALL clear snooze_cnt to 0.
REQ-026 DONE: !match SHALL move to IDLE; no retrigger is possible within the matching minute.
REQ-027 Priority, same cycle: dismiss / alarm_en low > snooze > tick-driven expiry.
REQ-028 setting_active SHALL only suppress triggering from IDLE; it does not affect RING or SNOOZE.
REQ-029 Inputs in IDLE or DONE other than those listed above (dismiss, snooze, tick) SHALL be ignored.
REQ-030 buzz SHALL be 0 in every state except RING.
REQ-031 Illegal or unreachable state encoding SHALL recover to IDLE on the next clock edge.

Reset
REQ-032 While rst==1 at a rising edge: state=IDLE, ring_cnt=0, snz_cnt=0, snooze_cnt=0, buzz=0, ringing=0, snoozed=0, alm_state=0.
REQ-033 rst SHALL override all inputs, including mid-RING or mid-SNOOZE; the first post-reset cycle evaluates trigger normally.

Configuration
REQ-034 Macro ALARM_BEEP_PATTERN_EN defined: in RING, buzz SHALL start at 1 on RING entry and toggle on each tick_1hz (1 s on / 1 s off).
REQ-035 Macro ALARM_BEEP_PATTERN_EN undefined: buzz SHALL equal ringing (continuous tone).

Verification (bench parameters RING_SEC=4, SNOOZE_MIN=1, MAX_SNOOZE=2)
REQ-036 alm=07:30, alarm_en=1, cur set to 07:30 -> next cycle alm_state=1, ringing=1, buzz=1; after 4 ticks -> alm_state=3; cur set to 07:31 -> alm_state=0.
REQ-037 RING, pulse snooze -> alm_state=2, snooze_cnt=1; after 60 ticks -> RING; snooze again -> snooze_cnt=2; third snooze in RING -> ignored, stays RING.
REQ-038 RING, dismiss and snooze in the same cycle -> alm_state=3, snooze_cnt=0; match still true -> remains 3.
REQ-039 setting_active=1 with match true -> stays IDLE; drop setting_active within the minute -> RING next cycle; in SNOOZE, drop alarm_en -> DONE.
REQ-040 rst asserted mid-SNOOZE with snooze_cnt=1 -> all outputs 0 next cycle; with macro defined, ring 4 ticks -> buzz sequence 1,0,1,0 then DONE.

Source files
------------

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm clock ring/snooze/dismiss state machine
//
// Optional feature macro: ALARM_BEEP_PATTERN_EN
//   defined   : buzz starts high on RING entry and toggles on every tick_1hz
//   undefined : buzz follows ringing (continuous tone)
//
// Parameters
//   RING_SEC    ring duration in tick_1hz pulses before auto-off
//   SNOOZE_MIN  snooze delay in minutes
//   MAX_SNOOZE  snoozes allowed per alarm event
//
// Ports
//   clk             system clock, all state on rising edge
//   rst             synchronous active-high reset
//   tick_1hz        one-cycle pulse per second
//   cur_hr/cur_min  current time (0-23 / 0-59)
//   alm_hr/alm_min  alarm time
//   alarm_en        alarm armed (level)
//   setting_active  time/alarm being edited (level), blocks triggering from IDLE
//   dismiss         stop request (pulse)
//   snooze          snooze request (pulse)
//   buzz            buzzer drive
//   ringing         high in RING
//   snoozed         high in SNOOZE
//   alm_state       IDLE=0, RING=1, SNOOZE=2, DONE=3
//   snooze_cnt      snoozes taken in the current event

module alarm_ctrl #(
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic [4:0] alm_hr,
    input  logic [5:0] alm_min,
    input  logic       alarm_en,
    input  logic       setting_active,
    input  logic       dismiss,
    input  logic       snooze,
    output logic       buzz,
    output logic       ringing,
    output logic       snoozed,
    output logic [1:0] alm_state,
    output logic [2:0] snooze_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int              RW        = (RING_SEC < 2) ? 1 : $clog2(RING_SEC + 1);
    localparam logic [RW-1:0]   RING_LOAD = RW'(RING_SEC);
    localparam logic [RW-1:0]   RING_ONE  = RW'(1);
    localparam logic [15:0]     SNZ_LOAD  = 16'(SNOOZE_MIN * 60);
    localparam logic [2:0]      SNZ_MAX   = 3'(MAX_SNOOZE);

    state_t         state_q;
    state_t         state_n;
    logic [RW-1:0]  ring_cnt;
    logic [RW-1:0]  ring_n;
    logic [15:0]    snz_cnt;
    logic [15:0]    snz_n;
    logic [2:0]     scnt_n;
    logic           buzz_n;

    logic match;
    logic trigger;
    logic stop_req;

    assign match    = (cur_hr == alm_hr) && (cur_min == alm_min);
    assign trigger  = match && alarm_en && !setting_active;
    assign stop_req = dismiss || !alarm_en;

    assign alm_state = state_q;

    // Next-state and counter update. Within RING/SNOOZE the if-chain order
    // sets the priority: stop request, then an accepted snooze, then tick expiry.
    // A snooze refused at the limit falls through so a coincident tick still counts.
    always_comb begin
        state_n = state_q;
        ring_n  = ring_cnt;
        snz_n   = snz_cnt;
        scnt_n  = snooze_cnt;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_n = ST_RING;
                    ring_n  = RING_LOAD;
                end
            end
            ST_RING: begin
                if (stop_req) begin
                    state_n = ST_DONE;
                    scnt_n  = 3'd0;
                    ring_n  = '0;
                end else if (snooze && (snooze_cnt < SNZ_MAX)) begin
                    state_n = ST_SNOOZE;
                    scnt_n  = snooze_cnt + 3'd1;
                    snz_n   = SNZ_LOAD;
                end else if (tick_1hz) begin
                    if (ring_cnt <= RING_ONE) begin
                        state_n = ST_DONE;
                        scnt_n  = 3'd0;
                        ring_n  = '0;
                    end else begin
                        ring_n = ring_cnt - RING_ONE;
                    end
                end
            end
            ST_SNOOZE: begin
                if (stop_req) begin
                    state_n = ST_DONE;
                    scnt_n  = 3'd0;
                    snz_n   = 16'd0;
                end else if (tick_1hz) begin
                    if (snz_cnt <= 16'd1) begin
                        state_n = ST_RING;
                        ring_n  = RING_LOAD;
                        snz_n   = 16'd0;
                    end else begin
                        snz_n = snz_cnt - 16'd1;
                    end
                end
            end
            ST_DONE: begin
                // Held until the matching minute passes so the same minute
                // cannot retrigger the alarm.
                if (!match) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                ring_n  = '0;
                snz_n   = 16'd0;
                scnt_n  = 3'd0;
            end
        endcase
    end

`ifdef ALARM_BEEP_PATTERN_EN
    logic beep_q;
    logic beep_n;

    // Beep phase: forced on when RING is entered, flipped by each tick that
    // keeps us in RING, and parked low elsewhere.
    always_comb begin
        beep_n = 1'b0;
        if (state_n == ST_RING) begin
            if (state_q != ST_RING) begin
                beep_n = 1'b1;
            end else if (tick_1hz) begin
                beep_n = ~beep_q;
            end else begin
                beep_n = beep_q;
            end
        end
    end

    assign buzz_n = beep_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            beep_q <= 1'b0;
        end else begin
            beep_q <= beep_n;
        end
    end
`else
    assign buzz_n = (state_n == ST_RING);
`endif

    // State, counters and decoded outputs all register together so every
    // output reflects the state the cycle after its cause is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ring_cnt   <= '0;
            snz_cnt    <= 16'd0;
            snooze_cnt <= 3'd0;
            buzz       <= 1'b0;
            ringing    <= 1'b0;
            snoozed    <= 1'b0;
        end else begin
            state_q    <= state_n;
            ring_cnt   <= ring_n;
            snz_cnt    <= snz_n;
            snooze_cnt <= scnt_n;
            buzz       <= buzz_n;
            ringing    <= (state_n == ST_RING);
            snoozed    <= (state_n == ST_SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed self-checking bench for alarm_ctrl

module tb_alarm_ctrl;

    localparam int RING_SEC   = 4;
    localparam int SNOOZE_MIN = 1;
    localparam int MAX_SNOOZE = 2;

`ifdef ALARM_BEEP_PATTERN_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic [4:0] cur_hr;
    logic [5:0] cur_min;
    logic [4:0] alm_hr;
    logic [5:0] alm_min;
    logic       alarm_en;
    logic       setting_active;
    logic       dismiss;
    logic       snooze;
    logic       buzz;
    logic       ringing;
    logic       snoozed;
    logic [1:0] alm_state;
    logic [2:0] snooze_cnt;

    int n_assert;
    int n_fail;

    alarm_ctrl #(
        .RING_SEC   (RING_SEC),
        .SNOOZE_MIN (SNOOZE_MIN),
        .MAX_SNOOZE (MAX_SNOOZE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tick_1hz       (tick_1hz),
        .cur_hr         (cur_hr),
        .cur_min        (cur_min),
        .alm_hr         (alm_hr),
        .alm_min        (alm_min),
        .alarm_en       (alarm_en),
        .setting_active (setting_active),
        .dismiss        (dismiss),
        .snooze         (snooze),
        .buzz           (buzz),
        .ringing        (ringing),
        .snoozed        (snoozed),
        .alm_state      (alm_state),
        .snooze_cnt     (snooze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pulse_tick();
        end
    endtask

    // Observed vector packs {buzz, ringing, snoozed, snooze_cnt, alm_state}.
    task automatic chk(input string tag, input logic [1:0] st, input logic [2:0] scnt, input logic bz);
        logic [7:0] obs;
        logic [7:0] exp;
        obs = {buzz, ringing, snoozed, snooze_cnt, alm_state};
        exp = {bz, (st == 2'd1), (st == 2'd2), scnt, st};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed {buzz,ring,snz,scnt,st}=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        tick_1hz       = 1'b0;
        cur_hr         = 5'd0;
        cur_min        = 6'd0;
        alm_hr         = 5'd7;
        alm_min        = 6'd30;
        alarm_en       = 1'b1;
        setting_active = 1'b0;
        dismiss        = 1'b0;
        snooze         = 1'b0;

        cyc();
        cyc();
        chk("reset", 2'd0, 3'd0, 1'b0);
        rst = 1'b0;
        cyc();
        chk("idle_no_match", 2'd0, 3'd0, 1'b0);

        // Basic ring and auto-off
        cur_hr = 5'd7; cur_min = 6'd30;
        cyc();
        chk("trigger_ring", 2'd1, 3'd0, 1'b1);
        ticks(RING_SEC - 1);
        chk("ring_before_expiry", 2'd1, 3'd0, BEEP ? 1'b0 : 1'b1);
        pulse_tick();
        chk("ring_expired_done", 2'd3, 3'd0, 1'b0);
        cyc();
        chk("done_held_on_match", 2'd3, 3'd0, 1'b0);
        cur_min = 6'd31;
        cyc();
        chk("done_to_idle", 2'd0, 3'd0, 1'b0);

        // Snooze cycle up to the limit
        cur_min = 6'd30;
        cyc();
        chk("retrigger_ring", 2'd1, 3'd0, 1'b1);
        snooze = 1'b1; cyc(); snooze = 1'b0;
        chk("snooze1", 2'd2, 3'd1, 1'b0);
        ticks(SNOOZE_MIN * 60 - 1);
        chk("snooze1_before_expiry", 2'd2, 3'd1, 1'b0);
        pulse_tick();
        chk("snooze1_back_to_ring", 2'd1, 3'd1, 1'b1);
        snooze = 1'b1; cyc(); snooze = 1'b0;
        chk("snooze2", 2'd2, 3'd2, 1'b0);
        ticks(SNOOZE_MIN * 60);
        chk("snooze2_back_to_ring", 2'd1, 3'd2, 1'b1);
        snooze = 1'b1; cyc(); snooze = 1'b0;
        chk("snooze3_ignored", 2'd1, 3'd2, 1'b1);
        ticks(RING_SEC);
        chk("ring_after_max_done", 2'd3, 3'd0, 1'b0);
        cur_min = 6'd31;
        cyc();
        chk("done_to_idle2", 2'd0, 3'd0, 1'b0);

        // Priorities: snooze beats expiry, dismiss beats snooze
        cur_min = 6'd30;
        cyc();
        chk("ring3", 2'd1, 3'd0, 1'b1);
        snooze = 1'b1; cyc(); snooze = 1'b0;
        chk("snooze_a", 2'd2, 3'd1, 1'b0);
        ticks(SNOOZE_MIN * 60);
        chk("snooze_a_ring", 2'd1, 3'd1, 1'b1);
        ticks(RING_SEC - 1);
        tick_1hz = 1'b1; snooze = 1'b1; cyc(); tick_1hz = 1'b0; snooze = 1'b0;
        chk("snooze_beats_expiry", 2'd2, 3'd2, 1'b0);
        ticks(SNOOZE_MIN * 60);
        chk("snooze_b_ring", 2'd1, 3'd2, 1'b1);
        dismiss = 1'b1; snooze = 1'b1; cyc(); dismiss = 1'b0; snooze = 1'b0;
        chk("dismiss_beats_snooze", 2'd3, 3'd0, 1'b0);
        cyc(); cyc();
        chk("done_no_retrigger", 2'd3, 3'd0, 1'b0);
        cur_min = 6'd31;
        cyc();
        chk("done_to_idle3", 2'd0, 3'd0, 1'b0);

        // setting_active and alarm_en
        setting_active = 1'b1; cur_min = 6'd30;
        cyc(); cyc();
        chk("setting_blocks_trigger", 2'd0, 3'd0, 1'b0);
        setting_active = 1'b0;
        cyc();
        chk("setting_dropped_ring", 2'd1, 3'd0, 1'b1);
        setting_active = 1'b1;
        cyc();
        chk("setting_ignored_in_ring", 2'd1, 3'd0, 1'b1);
        setting_active = 1'b0;
        snooze = 1'b1; cyc(); snooze = 1'b0;
        chk("snooze_c", 2'd2, 3'd1, 1'b0);
        alarm_en = 1'b0;
        cyc();
        chk("disarm_in_snooze_done", 2'd3, 3'd0, 1'b0);
        cur_min = 6'd31;
        cyc();
        chk("done_to_idle4", 2'd0, 3'd0, 1'b0);
        cur_min = 6'd30;
        cyc();
        chk("disarmed_no_trigger", 2'd0, 3'd0, 1'b0);
        alarm_en = 1'b1;
        cyc();
        chk("rearm_ring", 2'd1, 3'd0, 1'b1);

        // Reset mid-SNOOZE, then restart and check buzz pattern
        snooze = 1'b1; cyc(); snooze = 1'b0;
        chk("snooze_d", 2'd2, 3'd1, 1'b0);
        rst = 1'b1;
        cyc();
        chk("reset_mid_snooze", 2'd0, 3'd0, 1'b0);
        rst = 1'b0;
        cyc();
        chk("post_reset_trigger", 2'd1, 3'd0, 1'b1);
        pulse_tick();
        chk("beep_tick1", 2'd1, 3'd0, BEEP ? 1'b0 : 1'b1);
        pulse_tick();
        chk("beep_tick2", 2'd1, 3'd0, 1'b1);
        pulse_tick();
        chk("beep_tick3", 2'd1, 3'd0, BEEP ? 1'b0 : 1'b1);
        pulse_tick();
        chk("beep_done", 2'd3, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
